vga_frame_sniffer: RTL and testbench
====================================

VGA_FRAME_SNIFFER -- requirements
Module: vga_frame_sniffer

Interface
REQ-001 Parameter CLKS_PER_PIXEL, default 4: clk cycles per VGA pixel.
REQ-002 Parameter H_TOTAL_CLK, default 3200: expected clk cycles per line.
REQ-003 Parameter V_TOTAL, default 525: expected lines per frame.
REQ-004 Parameter H_START_CLK, default 579: clk cycles from hSync falling edge to the centre sample of visible pixel 0, including the one-cycle RGB output register.
REQ-005 Parameter H_ACTIVE, default 640; parameter V_START, default 35; parameter V_ACTIVE, default 480.
REQ-006 clk  input  1  system clock, shared with the VGA output path; one clock only.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 enable  input  1  capture enable; low forces the SEEK state.
REQ-009 hSync, vSync  input  1 each  active-low syncs from the display path.
REQ-010 vgaR, vgaG, vgaB  input  4 each  pixel colour; rgb = {vgaR,vgaG,vgaB}.
REQ-011 frame_done  output  1  one-cycle pulse when frame results update.
REQ-012 frame_checksum  output  16  checksum of the last complete frame.
REQ-013 frame_pixels  output  19  sampled visible pixels of the last frame.
REQ-014 frame_lines  output  10  hSync falling edges in the last frame.
REQ-015 line_clocks  output  12  clk count of the most recent complete line.
REQ-016 sync_error  output  1  last frame violated H_TOTAL_CLK or V_TOTAL.
REQ-017 locked  output  1  at least one complete frame has been measured since reset or enable rise.

Function
REQ-018 The block SHALL register hSync and vSync once and detect falling edges from the previous-sample and current-sample pair.
REQ-019 The FSM SHALL have two states: SEEK (counters idle, waits for a vSync fall) and FRAME (measuring).
REQ-020 SEEK to FRAME SHALL occur on a vSync fall with enable high. That first frame is partial and SHALL NOT produce frame_done.
REQ-021 In FRAME, a vSync fall SHALL latch all frame results, pulse frame_done for exactly one cycle, set locked, and restart the frame counters in the same cycle.
REQ-022 A vSync fall SHALL set line_idx to 0. An hSync fall in any other cycle SHALL increment line_idx, which saturates at 1023.
REQ-023 A coincident hSync fall and vSync fall SHALL count as the start of line 0 of the new frame, not as an extra line.
REQ-024 The line clock counter SHALL clear on every hSync fall, saturate at 4095, and be latched into line_clocks before clearing, provided line_idx > 0.
REQ-025 A pixel SHALL be sampled when both conditions hold:
  - V_START <= line_idx < V_START+V_ACTIVE;
  - clk_in_line = H_START_CLK + k*CLKS_PER_PIXEL, for 0 <= k < H_ACTIVE.
REQ-026 Each sample SHALL increment the pixel counter and update the checksum on the same clk edge.
REQ-027 sync_error SHALL be latched at frame end and set when either condition holds:
  - the frame line count != V_TOTAL;
  - any complete line in that frame had a clock count != H_TOTAL_CLK.
REQ-028 enable low SHALL return the block to SEEK within one cycle and clear locked. Latched result outputs SHALL hold their values.
REQ-029 Checksum and pixel counter arithmetic SHALL wrap modulo 2^16 and 2^19 respectively.

Reset
REQ-030 Reset SHALL force state SEEK and clear every output to 0: frame_done, frame_checksum, frame_pixels, frame_lines, line_clocks, sync_error, locked.
REQ-031 Reset SHALL also clear the sync history registers and all internal counters.
REQ-032 Reset asserted mid-frame SHALL discard that frame entirely; the next vSync fall re-enters FRAME with no frame_done.

Configuration
REQ-033 With macro SNIFF_CRC_EN defined, the checksum SHALL be CRC-16-CCITT:
  - polynomial 0x1021, initial value 0xFFFF;
  - 12 rgb bits shifted MSB first per sample, all in one clk.
REQ-034 Without SNIFF_CRC_EN, the checksum SHALL be the additive sum of zero-extended rgb, with initial value 0x0000.

Structure
REQ-035 A shared package SHALL hold the FSM state typedef, the default timing constants, and the CRC polynomial and initial value.
REQ-036 One sub-module, sync_edge_detect, SHALL register a sync input and emit a one-cycle falling-edge pulse; it is instantiated twice.

Verification
REQ-037 Reset, then standard 640x480 timing with rgb=12'h001, SNIFF_CRC_EN undefined, for two vSync falls -> one frame_done, frame_pixels=307200, frame_checksum=0xB000, frame_lines=525, line_clocks=3200, sync_error=0, locked=1.
REQ-038 Frame of 524 lines -> frame_lines=524, sync_error=1; next correct frame -> sync_error=0.
REQ-039 One line of 3196 clocks inside a frame -> line_clocks=3196 after that line, sync_error=1 at frame end.
REQ-040 Reset pulse at line 200 of a frame -> all outputs 0; no frame_done at the next vSync fall; frame_done at the one after.
REQ-041 enable low for 3 frames, then high -> no frame_done while low, locked=0; first frame_done on the second vSync fall after enable rises.
REQ-042 SNIFF_CRC_EN defined, all-zero frame -> frame_checksum equals the package CRC model run over 307200 zero 12-bit words, and differs from the additive-mode result of 0x0000.

Source files
------------

// File: rtl/vga_frame_sniffer_pkg.sv
// Shared types and timing constants for the VGA frame sniffer.
// Define SNIFF_CRC_EN to switch the checksum to CRC-16-CCITT.
package vga_frame_sniffer_pkg;

  typedef enum logic {
    SEEK  = 1'b0,
    FRAME = 1'b1
  } state_t;

  localparam int DEF_CLKS_PER_PIXEL = 4;
  localparam int DEF_H_TOTAL_CLK    = 3200;
  localparam int DEF_V_TOTAL        = 525;
  localparam int DEF_H_START_CLK    = 579;
  localparam int DEF_H_ACTIVE       = 640;
  localparam int DEF_V_START        = 35;
  localparam int DEF_V_ACTIVE       = 480;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Shifts all 12 rgb bits, MSB first, through the CRC in one step.
  function automatic logic [15:0] crc16_rgb(
    input logic [15:0] crc,
    input logic [11:0] rgb
  );
    logic [15:0] c;
    c = crc;
    for (int i = 11; i >= 0; i--) begin
      if (c[15] ^ rgb[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_frame_sniffer_sync_edge_detect.sv
// Registers one active-low sync input and flags its falling edge.
// SNIFF_CRC_EN has no effect on this block.
module sync_edge_detect
  import vga_frame_sniffer_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic sync_in,
  output logic fall
);

  logic sync_q;
  logic sync_d;

  always_comb sync_d = sync_in;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= 1'b0;
    else       sync_q <= sync_d;
  end

  assign fall = sync_q & ~sync_in;

endmodule

// File: rtl/vga_frame_sniffer.sv
// VGA frame sniffer: measures line/frame timing and checksums visible pixels.
// Define SNIFF_CRC_EN for a CRC-16-CCITT checksum instead of an additive sum.
module vga_frame_sniffer
  import vga_frame_sniffer_pkg::*;
#(
  parameter int CLKS_PER_PIXEL = DEF_CLKS_PER_PIXEL,
  parameter int H_TOTAL_CLK    = DEF_H_TOTAL_CLK,
  parameter int V_TOTAL        = DEF_V_TOTAL,
  parameter int H_START_CLK    = DEF_H_START_CLK,
  parameter int H_ACTIVE       = DEF_H_ACTIVE,
  parameter int V_START        = DEF_V_START,
  parameter int V_ACTIVE       = DEF_V_ACTIVE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        hSync,
  input  logic        vSync,
  input  logic [3:0]  vgaR,
  input  logic [3:0]  vgaG,
  input  logic [3:0]  vgaB,
  output logic        frame_done,
  output logic [15:0] frame_checksum,
  output logic [18:0] frame_pixels,
  output logic [9:0]  frame_lines,
  output logic [11:0] line_clocks,
  output logic        sync_error,
  output logic        locked
);

`ifdef SNIFF_CRC_EN
  localparam logic [15:0] CSUM_INIT = CRC_INIT;
`else
  localparam logic [15:0] CSUM_INIT = 16'h0000;
`endif

  state_t      state_q, state_d;
  logic [9:0]  line_idx_q, line_idx_d;
  logic [9:0]  lines_q, lines_d;
  logic [11:0] clk_q, clk_d;
  logic [15:0] csum_q, csum_d;
  logic [18:0] pix_q, pix_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic [15:0] fcsum_q, fcsum_d;
  logic [18:0] fpix_q, fpix_d;
  logic [9:0]  flines_q, flines_d;
  logic [11:0] lclk_q, lclk_d;
  logic        serr_q, serr_d;
  logic        locked_q, locked_d;

  logic        h_fall, v_fall;
  logic        line_end, bad_line, sample;
  logic [11:0] rgb;
  int          clk_off;

  sync_edge_detect u_hsync (
    .clk     (clk),
    .reset   (reset),
    .sync_in (hSync),
    .fall    (h_fall)
  );

  sync_edge_detect u_vsync (
    .clk     (clk),
    .reset   (reset),
    .sync_in (vSync),
    .fall    (v_fall)
  );

  function automatic logic [15:0] csum_next(
    input logic [15:0] c,
    input logic [11:0] px
  );
`ifdef SNIFF_CRC_EN
    return crc16_rgb(c, px);
`else
    return c + {4'h0, px};
`endif
  endfunction

  always_comb begin
    rgb      = {vgaR, vgaG, vgaB};
    clk_off  = int'(clk_q) - H_START_CLK;
    line_end = h_fall && (line_idx_q != 10'd0);
    bad_line = line_end && (int'(clk_q) != H_TOTAL_CLK);
    sample   = (int'(line_idx_q) >= V_START)
            && (int'(line_idx_q) < V_START + V_ACTIVE)
            && (clk_off >= 0)
            && (clk_off < H_ACTIVE * CLKS_PER_PIXEL)
            && (clk_off % CLKS_PER_PIXEL == 0);

    state_d    = state_q;
    line_idx_d = line_idx_q;
    lines_d    = lines_q;
    clk_d      = clk_q;
    csum_d     = csum_q;
    pix_d      = pix_q;
    err_d      = err_q;
    done_d     = 1'b0;
    fcsum_d    = fcsum_q;
    fpix_d     = fpix_q;
    flines_d   = flines_q;
    lclk_d     = lclk_q;
    serr_d     = serr_q;
    locked_d   = locked_q;

    if (state_q == FRAME && enable) begin
      // clk_q counts clocks elapsed since the last hSync fall
      if (h_fall)                clk_d = 12'd1;
      else if (clk_q != 12'hFFF) clk_d = clk_q + 12'd1;
      if (h_fall && line_idx_q != 10'd1023) line_idx_d = line_idx_q + 10'd1;
      if (h_fall && lines_q != 10'd1023)    lines_d = lines_q + 10'd1;
      if (line_end) lclk_d = clk_q;
      if (bad_line) err_d = 1'b1;
      if (sample) begin
        pix_d  = pix_q + 19'd1;
        csum_d = csum_next(csum_q, rgb);
      end
    end else begin
      line_idx_d = '0;
      lines_d    = '0;
      clk_d      = '0;
      csum_d     = CSUM_INIT;
      pix_d      = '0;
      err_d      = 1'b0;
    end

    if (v_fall && enable) begin
      if (state_q == FRAME) begin
        done_d   = 1'b1;
        locked_d = 1'b1;
        fcsum_d  = csum_q;
        fpix_d   = pix_q;
        flines_d = lines_q;
        serr_d   = err_q || bad_line || (int'(lines_q) != V_TOTAL);
      end
      state_d    = FRAME;
      line_idx_d = '0;
      lines_d    = {9'd0, h_fall};
      clk_d      = 12'd1;
      csum_d     = CSUM_INIT;
      pix_d      = '0;
      err_d      = 1'b0;
    end

    if (!enable) begin
      state_d  = SEEK;
      locked_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SEEK;
      line_idx_q <= '0;
      lines_q    <= '0;
      clk_q      <= '0;
      csum_q     <= '0;
      pix_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      fcsum_q    <= '0;
      fpix_q     <= '0;
      flines_q   <= '0;
      lclk_q     <= '0;
      serr_q     <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_idx_q <= line_idx_d;
      lines_q    <= lines_d;
      clk_q      <= clk_d;
      csum_q     <= csum_d;
      pix_q      <= pix_d;
      err_q      <= err_d;
      done_q     <= done_d;
      fcsum_q    <= fcsum_d;
      fpix_q     <= fpix_d;
      flines_q   <= flines_d;
      lclk_q     <= lclk_d;
      serr_q     <= serr_d;
      locked_q   <= locked_d;
    end
  end

  assign frame_done     = done_q;
  assign frame_checksum = fcsum_q;
  assign frame_pixels   = fpix_q;
  assign frame_lines    = flines_q;
  assign line_clocks    = lclk_q;
  assign sync_error     = serr_q;
  assign locked         = locked_q;

endmodule

// File: tb/tb_vga_frame_sniffer.sv
// Bench for vga_frame_sniffer on a shrunken raster (40 clk x 12 lines).
// Per-frame expectations are queued and checked whenever frame_done fires.
module tb_vga_frame_sniffer;

  localparam int CPP = 2;
  localparam int HT  = 40;
  localparam int VT  = 12;
  localparam int HS  = 9;
  localparam int HA  = 8;
  localparam int VS  = 2;
  localparam int VA  = 6;

`ifdef SNIFF_CRC_EN
  localparam logic [15:0] CSUM0 = 16'hFFFF;
`else
  localparam logic [15:0] CSUM0 = 16'h0000;
`endif

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic        enable = 1'b1;
  logic        hSync  = 1'b1;
  logic        vSync  = 1'b1;
  logic [3:0]  vgaR   = '0;
  logic [3:0]  vgaG   = '0;
  logic [3:0]  vgaB   = '0;
  logic        frame_done;
  logic [15:0] frame_checksum;
  logic [18:0] frame_pixels;
  logic [9:0]  frame_lines;
  logic [11:0] line_clocks;
  logic        sync_error;
  logic        locked;

  vga_frame_sniffer #(
    .CLKS_PER_PIXEL (CPP),
    .H_TOTAL_CLK    (HT),
    .V_TOTAL        (VT),
    .H_START_CLK    (HS),
    .H_ACTIVE       (HA),
    .V_START        (VS),
    .V_ACTIVE       (VA)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .hSync          (hSync),
    .vSync          (vSync),
    .vgaR           (vgaR),
    .vgaG           (vgaG),
    .vgaB           (vgaB),
    .frame_done     (frame_done),
    .frame_checksum (frame_checksum),
    .frame_pixels   (frame_pixels),
    .frame_lines    (frame_lines),
    .line_clocks    (line_clocks),
    .sync_error     (sync_error),
    .locked         (locked)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] csum;
    logic [18:0] pix;
    logic [9:0]  lines;
    logic [11:0] lclk;
    logic        serr;
  } exp_t;

  exp_t sbq[$];
  exp_t pend;
  exp_t mon_e;
  bit   pend_v = 1'b0;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] msum(input logic [15:0] c, input logic [11:0] px);
`ifdef SNIFF_CRC_EN
    logic [15:0] r;
    r = c;
    for (int i = 11; i >= 0; i--)
      r = (r[15] ^ px[i]) ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
`else
    return c + {4'h0, px};
`endif
  endfunction

  task automatic tick(input logic en, input logic hs, input logic vs,
                      input logic rst, input logic [11:0] px);
    @(negedge clk);
    enable = en;
    hSync  = hs;
    vSync  = vs;
    reset  = rst;
    {vgaR, vgaG, vgaB} = px;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_done"},   frame_done, 0);
    chk({tag, "_csum"},   frame_checksum, 0);
    chk({tag, "_pix"},    frame_pixels, 0);
    chk({tag, "_lines"},  frame_lines, 0);
    chk({tag, "_lclk"},   line_clocks, 0);
    chk({tag, "_serr"},   sync_error, 0);
    chk({tag, "_locked"}, locked, 0);
  endtask

  // One frame: hSync low for 4 clk per line, vSync low for lines 0-1.
  // mode 0 random rgb, 1 constant 1, 2 all zero; rst_l>=0 pulses reset.
  task automatic run_frame(input logic en, input int nl, input int odd_l,
                           input int odd_n, input int mode, input int rst_l);
    exp_t e;
    int n, off;
    logic [11:0] px;
    if (pend_v && en) sbq.push_back(pend);
    pend_v  = 1'b0;
    e.csum  = CSUM0;
    e.pix   = '0;
    e.lines = 10'(nl);
    e.lclk  = '0;
    e.serr  = (nl != VT);
    for (int l = 0; l < nl; l++) begin
      n = (l == odd_l) ? odd_n : HT;
      if (l > 0 && n != HT) e.serr = 1'b1;
      if (l == nl - 1) e.lclk = 12'((n > 4095) ? 4095 : n);
      for (int c = 0; c < n; c++) begin
        px = (mode == 0) ? 12'($urandom) : (mode == 1) ? 12'h001 : 12'h000;
        tick(en, c >= 4, l >= 2, l == rst_l && c == 5, px);
        off = c - HS;
        if (l >= VS && l < VS + VA && off >= 0 && off % CPP == 0 && off / CPP < HA) begin
          e.pix  = e.pix + 19'd1;
          e.csum = msum(e.csum, px);
        end
        if (l == rst_l && c == 6) check_zero("midreset");
        if (en && rst_l < 0 && odd_l >= 0 && l == odd_l + 1 && c == 2)
          chk("line_clocks_mid", line_clocks, (odd_n > 4095) ? 4095 : odd_n);
        if (!en && l == 1 && c == 2) chk("locked_low", locked, 0);
      end
    end
    if (en && rst_l < 0) begin
      pend   = e;
      pend_v = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (frame_done) begin
      chk("done_expected", sbq.size() > 0, 1);
      if (sbq.size() > 0) begin
        mon_e = sbq.pop_front();
        chk("frame_checksum", frame_checksum, mon_e.csum);
        chk("frame_pixels", frame_pixels, mon_e.pix);
        chk("frame_lines", frame_lines, mon_e.lines);
        chk("line_clocks", line_clocks, mon_e.lclk);
        chk("sync_error", sync_error, mon_e.serr);
        chk("locked", locked, 1);
      end
    end
  end

  initial begin
    repeat (3) tick(1'b1, 1'b1, 1'b1, 1'b1, 12'h000);
    tick(1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
    check_zero("reset");
    run_frame(1'b1, VT, 3, HT, 1, -1);
    run_frame(1'b1, VT - 1, 3, HT, 0, -1);
    run_frame(1'b1, VT, 3, HT, 0, -1);
    run_frame(1'b1, VT, 5, HT - 4, 0, -1);
    run_frame(1'b1, VT, 7, 4200, 0, -1);
    run_frame(1'b1, VT + 1, VT, HT - 3, 2, -1);
    run_frame(1'b1, VT, 3, HT, 0, 4);
    run_frame(1'b1, VT, 3, HT, 0, -1);
    run_frame(1'b1, VT, 3, HT, 2, -1);
    repeat (3) run_frame(1'b0, VT, 3, HT, 0, -1);
    run_frame(1'b1, VT, 3, HT, 0, -1);
    for (int i = 0; i < 6; i++)
      run_frame(1'b1, $urandom_range(VT + 1, VT - 1), $urandom_range(VT - 2, 1),
                $urandom_range(45, 30), 0, -1);
    run_frame(1'b1, 3, 1, HT, 0, -1);
    repeat (20) tick(1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
    chk("queue_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
